// File: rtl/run_pkg.sv
// Shared types and constants for the run sample generator and its
// triangle-wave update helpers.
package run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int HR_WIDTH    = 8;
    localparam int STEPS_WIDTH = 3;

endpackage

// File: rtl/run_sample_generator_tri_wave_step.sv
// Bounded triangle-wave value: saturating up/down step whose direction
// turns on the freshly computed value.
module tri_wave_step
    import run_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int INIT  = 0,
    parameter int STEP  = 1,
    parameter int MIN   = 0,
    parameter int MAX   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] value,
    output logic             dir
);

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH:0]   STEP_V = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] value_r;
    logic             dir_r;
    logic [WIDTH-1:0] base_val_s;
    logic             base_dir_s;
    logic [WIDTH-1:0] next_val_s;
    logic             next_dir_s;
    logic [WIDTH:0]   sum_s;

    // Next value: optional reload, then one saturating step with the turn test on the result.
    always_comb begin
        base_val_s = load ? INIT_V : value_r;
        base_dir_s = load ? DIR_UP : dir_r;
        sum_s      = '0;
        next_val_s = base_val_s;
        next_dir_s = base_dir_s;
        if (advance) begin
            if (base_dir_s == DIR_UP) begin
                sum_s = {1'b0, base_val_s} + STEP_V;
                if (sum_s[WIDTH]) begin
                    next_val_s = '1;
                end else begin
                    next_val_s = sum_s[WIDTH-1:0];
                end
                if (next_val_s >= MAX_V) begin
                    next_dir_s = DIR_DOWN;
                end else begin
                    next_dir_s = DIR_UP;
                end
            end else begin
                // A borrow out of the top bit means the value would go below zero.
                sum_s = {1'b0, base_val_s} - STEP_V;
                if (sum_s[WIDTH]) begin
                    next_val_s = '0;
                end else begin
                    next_val_s = sum_s[WIDTH-1:0];
                end
                if (next_val_s <= MIN_V) begin
                    next_dir_s = DIR_UP;
                end else begin
                    next_dir_s = DIR_DOWN;
                end
            end
        end else begin
            next_val_s = base_val_s;
            next_dir_s = base_dir_s;
        end
    end

    // Value and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= INIT_V;
            dir_r   <= DIR_UP;
        end else begin
            value_r <= next_val_s;
            dir_r   <= next_dir_s;
        end
    end

    assign value = value_r;
    assign dir   = dir_r;

endmodule

// File: rtl/run_sample_generator.sv
// Sample producer for the step calculator: emits triangle-wave heart rate
// and cadence with a one-cycle valid strobe every SAMPLE_PERIOD cycles.
module run_sample_generator
    import run_pkg::*;
#(
    parameter int HR_INIT       = 110,
    parameter int HR_STEP       = 11,
    parameter int HR_MIN        = 121,
    parameter int HR_MAX        = 198,
    parameter int STEPS_MIN     = 1,
    parameter int STEPS_MAX     = 4,
    parameter int STRIDE        = 75,
    parameter int SAMPLE_PERIOD = 2,
    parameter int NUM_SAMPLES   = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [HR_WIDTH-1:0]    hr_out,
    output logic [STEPS_WIDTH-1:0] steps_per_second,
    output logic [7:0]             stride_length,
    output logic                   valid_out,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             sample_count
);

    localparam logic [15:0] GAP_LOAD = 16'(SAMPLE_PERIOD - 2);
    localparam logic [7:0]  NUM_V    = 8'(NUM_SAMPLES);
    localparam logic [7:0]  STRIDE_V = 8'(STRIDE);

    run_state_e  state_r, state_s;
    logic [15:0] gap_r, gap_s;
    logic [7:0]  count_r, count_s;
    logic [7:0]  stride_r, stride_s;
    logic        valid_r, valid_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        load_s, advance_s;
    logic        hr_dir_s, steps_dir_s;
    logic        unused_dir_s;

    tri_wave_step #(
        .WIDTH(HR_WIDTH), .INIT(HR_INIT), .STEP(HR_STEP), .MIN(HR_MIN), .MAX(HR_MAX)
    ) u_hr (
        .clk(clk), .rst_n(rst_n), .load(load_s), .advance(advance_s),
        .value(hr_out), .dir(hr_dir_s)
    );

    tri_wave_step #(
        .WIDTH(STEPS_WIDTH), .INIT(0), .STEP(1), .MIN(STEPS_MIN), .MAX(STEPS_MAX)
    ) u_steps (
        .clk(clk), .rst_n(rst_n), .load(load_s), .advance(advance_s),
        .value(steps_per_second), .dir(steps_dir_s)
    );

    assign unused_dir_s = hr_dir_s ^ steps_dir_s;

    // Next-state and output decode; abort overrides start and any pending update.
    always_comb begin
        state_s   = state_r;
        gap_s     = gap_r;
        count_s   = count_r;
        stride_s  = stride_r;
        valid_s   = 1'b0;
        busy_s    = busy_r;
        done_s    = done_r;
        load_s    = 1'b0;
        advance_s = 1'b0;
        if (abort) begin
            state_s  = ST_IDLE;
            busy_s   = 1'b0;
            done_s   = 1'b0;
            stride_s = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        load_s    = 1'b1;
                        advance_s = 1'b1;
                        valid_s   = 1'b1;
                        count_s   = 8'd1;
                        busy_s    = 1'b1;
                        done_s    = 1'b0;
                        stride_s  = STRIDE_V;
                        state_s   = ST_EMIT;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_EMIT: begin
                    if (count_r == NUM_V) begin
                        state_s  = ST_DONE;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                        stride_s = 8'd0;
                    end else begin
                        state_s = ST_GAP;
                        gap_s   = GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_r == 16'd0) begin
                        advance_s = 1'b1;
                        valid_s   = 1'b1;
                        count_s   = count_r + 8'd1;
                        state_s   = ST_EMIT;
                    end else begin
                        gap_s = gap_r - 16'd1;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                    done_s   = 1'b0;
                    stride_s = 8'd0;
                end
            endcase
        end
    end

    // State and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            gap_r    <= 16'd0;
            count_r  <= 8'd0;
            stride_r <= 8'd0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            gap_r    <= gap_s;
            count_r  <= count_s;
            stride_r <= stride_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign stride_length = stride_r;
    assign valid_out     = valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign sample_count  = count_r;

endmodule

// File: tb/tb_run_sample_generator.sv
// Directed bench for run_sample_generator: default and alternate-HR instances
// run in lockstep against a table of hand-computed strobe values.
module tb_run_sample_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] hr_a, stride_a, count_a, hr_b, stride_b, count_b;
    logic [2:0] steps_a, steps_b;
    logic       valid_a, busy_a, done_a, valid_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_sample_generator dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hr_out(hr_a), .steps_per_second(steps_a), .stride_length(stride_a),
        .valid_out(valid_a), .busy(busy_a), .done(done_a), .sample_count(count_a)
    );

    run_sample_generator #(
        .HR_INIT(88), .HR_STEP(8), .HR_MIN(96), .HR_MAX(152)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hr_out(hr_b), .steps_per_second(steps_b), .stride_length(stride_b),
        .valid_out(valid_b), .busy(busy_b), .done(done_b), .sample_count(count_b)
    );

    typedef struct {
        bit         inj_start;
        int         exp_gap;
        logic [7:0] exp_hr_a;
        logic [7:0] exp_hr_b;
        logic [2:0] exp_steps;
    } vec_t;

    vec_t vecs[20];

    int hr_a_tab[20]  = '{121, 132, 143, 154, 165, 176, 187, 198, 187, 176,
                          165, 154, 143, 132, 121, 132, 143, 154, 165, 176};
    int hr_b_tab[20]  = '{96, 104, 112, 120, 128, 136, 144, 152, 144, 136,
                          128, 120, 112, 104, 96, 104, 112, 120, 128, 136};
    int steps_tab[20] = '{1, 2, 3, 4, 3, 2, 1, 2, 3, 4,
                          3, 2, 1, 2, 3, 4, 3, 2, 1, 2};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold start for the first two edges when inj is set, then wait for a strobe.
    task automatic wait_strobe(input bit inj, output int cycles);
        cycles = 0;
        start  = inj;
        do begin
            tick();
            cycles++;
            if (cycles >= 2) start = 1'b0;
        end while (!valid_a && cycles < 40);
        start = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  seen;

        for (int i = 0; i < 20; i++) begin
            vecs[i].inj_start = (i == 0) || (i == 3) || (i == 9);
            vecs[i].exp_gap   = (i == 0) ? 1 : 2;
            vecs[i].exp_hr_a  = 8'(hr_a_tab[i]);
            vecs[i].exp_hr_b  = 8'(hr_b_tab[i]);
            vecs[i].exp_steps = 3'(steps_tab[i]);
        end

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        check("reset_hr", hr_a, 110);
        check("reset_hr_b", hr_b, 88);
        check("reset_steps", steps_a, 0);
        check("reset_stride", stride_a, 0);
        check("reset_valid", valid_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_count", count_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full run; strobes 4 and 10 are preceded by a start that must be ignored.
        for (int i = 0; i < 20; i++) begin
            wait_strobe(vecs[i].inj_start, cyc);
            check($sformatf("spacing[%0d]", i), cyc, vecs[i].exp_gap);
            check($sformatf("hr_a[%0d]", i), hr_a, vecs[i].exp_hr_a);
            check($sformatf("hr_b[%0d]", i), hr_b, vecs[i].exp_hr_b);
            check($sformatf("steps_a[%0d]", i), steps_a, vecs[i].exp_steps);
            check($sformatf("steps_b[%0d]", i), steps_b, vecs[i].exp_steps);
            check($sformatf("count[%0d]", i), count_a, i + 1);
            check($sformatf("stride[%0d]", i), stride_a, 75);
            check($sformatf("busy[%0d]", i), busy_a, 1);
            check($sformatf("valid_b[%0d]", i), valid_b, 1);
        end
        tick();
        check("end_done", done_a, 1);
        check("end_done_b", done_b, 1);
        check("end_busy", busy_a, 0);
        check("end_valid", valid_a, 0);
        check("end_count", count_a, 20);
        check("end_stride", stride_a, 0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (valid_a) seen = 1'b1;
        end
        check("done_no_strobe", seen, 0);
        check("done_sticky", done_a, 1);
        check("done_hr_hold", hr_a, 176);

        // Abort in the gap after the 5th strobe, on the edge that would emit the 6th.
        for (int i = 0; i < 5; i++) begin
            wait_strobe(i == 0, cyc);
        end
        check("abort_pre_hr", hr_a, 165);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", valid_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_count", count_a, 5);
        check("abort_hr", hr_a, 165);
        check("abort_steps", steps_a, 3);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (valid_a) seen = 1'b1;
        end
        check("abort_no_strobe", seen, 0);
        wait_strobe(1'b1, cyc);
        check("restart_gap", cyc, 1);
        check("restart_hr", hr_a, 121);
        check("restart_steps", steps_a, 1);
        check("restart_count", count_a, 1);

        // Start and abort together mid-run, then again from IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        check("sa_run_busy", busy_a, 0);
        check("sa_run_valid", valid_a, 0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_idle_busy", busy_a, 0);
        check("sa_idle_valid", valid_a, 0);
        check("sa_idle_done", done_a, 0);
        check("sa_idle_count", count_a, 1);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (valid_a || busy_a) seen = 1'b1;
        end
        check("sa_stays_idle", seen, 0);

        // Asynchronous reset in the gap, observed before the next clock edge.
        wait_strobe(1'b1, cyc);
        wait_strobe(1'b0, cyc);
        check("rst_pre_hr", hr_a, 132);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hr", hr_a, 110);
        check("arst_hr_b", hr_b, 88);
        check("arst_steps", steps_a, 0);
        check("arst_valid", valid_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_count", count_a, 0);
        check("arst_stride", stride_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", valid_a, 0);
        check("post_rst_busy", busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
